// File: rtl/dcache_victim_pkg.sv
// Shared constants and entry metadata for the data-cache victim buffer.
// Tags are stored at a fixed maximum width so one metadata type serves every TAG_BITS setting.
package dcache_victim_pkg;

    localparam int DEF_NUM_ENTRIES = 4;
    localparam int DEF_LINE_WIDTH  = 128;
    localparam int DEF_TAG_BITS    = 23;
    localparam int MAX_TAG_BITS    = 64;

    typedef logic [MAX_TAG_BITS-1:0] meta_tag_t;

    typedef struct packed {
        meta_tag_t tag;
        logic      valid;
        logic      dirty;
    } victim_meta_t;

    typedef enum logic [1:0] {
        ALLOC_MERGE = 2'd0,
        ALLOC_FREE  = 2'd1,
        ALLOC_EVICT = 2'd2
    } alloc_kind_t;

    function automatic meta_tag_t widen_tag(input logic [MAX_TAG_BITS-1:0] tag);
        return tag;
    endfunction

endpackage

// File: rtl/dcache_victim_buf_wb_reg.sv
// One-entry valid/ready holding register for dirty victims waiting to be written back.
// The payload is only captured on load and is not reset; reset just drops the valid flag.
module victim_wb_reg #(
    parameter int TAG_BITS   = 23,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [TAG_BITS-1:0]   load_tag_i,
    input  logic [LINE_WIDTH-1:0] load_data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [TAG_BITS-1:0]   tag_o,
    output logic [LINE_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;

    // A load in the same cycle as a drain replaces the drained entry.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            tag_d   = load_tag_i;
            data_d  = load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dcache_victim_buf.sv
// Fully-associative victim buffer sitting beside the data cache: zero-latency lookup,
// merge-or-allocate insert, round-robin replacement, and a single write-back slot for dirty victims.
module dcache_victim_buf
    import dcache_victim_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int TAG_BITS    = DEF_TAG_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TAG_BITS-1:0]            lookup_tag_i,
    output logic                           lookup_hit_o,
    output logic [LINE_WIDTH-1:0]          lookup_data_o,
    output logic                           lookup_dirty_o,
    input  logic                           take_i,
    input  logic                           insert_valid_i,
    output logic                           insert_ready_o,
    input  logic [TAG_BITS-1:0]            insert_tag_i,
    input  logic [LINE_WIDTH-1:0]          insert_data_i,
    input  logic                           insert_dirty_i,
    output logic                           wb_valid_o,
    input  logic                           wb_ready_i,
    output logic [TAG_BITS-1:0]            wb_tag_o,
    output logic [LINE_WIDTH-1:0]          wb_data_o,
    output logic [$clog2(NUM_ENTRIES):0]   count_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    victim_meta_t          meta_q [NUM_ENTRIES];
    victim_meta_t          meta_d [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0] data_q [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0] data_d [NUM_ENTRIES];
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    meta_tag_t             lookup_tag_w;
    meta_tag_t             insert_tag_w;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  match_found;
    logic [IDX_W-1:0]      match_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    alloc_kind_t           alloc_kind;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  insert_fire;
    logic                  take_fire;
    logic                  wb_load;

    assign lookup_tag_w = widen_tag(MAX_TAG_BITS'(lookup_tag_i));
    assign insert_tag_w = widen_tag(MAX_TAG_BITS'(insert_tag_i));

    // Lowest matching index wins when more than one entry carries the probed tag.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && meta_q[i].valid && (meta_q[i].tag == lookup_tag_w)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign lookup_hit_o   = hit;
    assign lookup_data_o  = hit ? data_q[hit_idx] : '0;
    assign lookup_dirty_o = hit & meta_q[hit_idx].dirty;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!match_found && meta_q[i].valid && (meta_q[i].tag == insert_tag_w)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!free_found && !meta_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        alloc_kind = ALLOC_EVICT;
        alloc_idx  = ptr_q;
        if (match_found) begin
            alloc_kind = ALLOC_MERGE;
            alloc_idx  = match_idx;
        end else if (free_found) begin
            alloc_kind = ALLOC_FREE;
            alloc_idx  = free_idx;
        end
    end

    assign insert_ready_o = !wb_valid_o || wb_ready_i;
    assign insert_fire    = insert_valid_i && insert_ready_o;
    assign take_fire      = take_i && hit;
    assign wb_load        = insert_fire && (alloc_kind == ALLOC_EVICT) && meta_q[ptr_q].dirty;

    // The insert is applied after the take so it wins when both hit the same entry.
    always_comb begin
        meta_d = meta_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (take_fire) begin
            meta_d[hit_idx].valid = 1'b0;
            meta_d[hit_idx].dirty = 1'b0;
        end
        if (insert_fire) begin
            meta_d[alloc_idx].valid = 1'b1;
            meta_d[alloc_idx].tag   = insert_tag_w;
            meta_d[alloc_idx].dirty = insert_dirty_i |
                                      ((alloc_kind == ALLOC_MERGE) & meta_q[alloc_idx].dirty);
            data_d[alloc_idx]       = insert_data_i;
            if (alloc_kind == ALLOC_EVICT) begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            count_d = count_d + CNT_W'(meta_d[i].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                meta_q[i].valid <= 1'b0;
                meta_q[i].dirty <= 1'b0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            meta_q  <= meta_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign count_o = count_q;

    victim_wb_reg #(
        .TAG_BITS   (TAG_BITS),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wb_load),
        .load_tag_i  (meta_q[ptr_q].tag[TAG_BITS-1:0]),
        .load_data_i (data_q[ptr_q]),
        .ready_i     (wb_ready_i),
        .valid_o     (wb_valid_o),
        .tag_o       (wb_tag_o),
        .data_o      (wb_data_o)
    );

endmodule
